// File: rtl/fpga_board_ctrl.sv
// Board control: project reset sequencing from PLL lock and a soft-reset button, button and switch
// conditioning, and a four-mode LED display. Define BOARD_CTRL_HEARTBEAT_EN to build the heartbeat counter.
//
// state     | meaning
// WAIT_LOCK | project held in reset until the synchronised PLL lock is seen
// HOLD      | lock seen, hold counter running down, project still in reset
// RUN       | project reset released

module fpga_board_ctrl #(
  parameter int NUM_BTN     = 5,
  parameter int NUM_SW      = 16,
  parameter int NUM_LED     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 65536,
  parameter int RST_HOLD    = 1024,
  parameter int RST_BTN     = 0,
  parameter int MODE_BTN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [NUM_LED-1:0] mon_in,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_SW-1:0]  sw_sync,
  output logic               proj_rst_n,
  output logic [NUM_LED-1:0] led,
  output logic [1:0]         led_mode
);

  localparam int DW = $clog2(DB_CYCLES);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] lock_sr;
  logic [NUM_BTN-1:0]     btn_sr [SYNC_STAGES];
  logic [NUM_SW-1:0]      sw_sr  [SYNC_STAGES];
  logic                   lock_sync;
  logic [NUM_BTN-1:0]     btn_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sr <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        btn_sr[s] <= '0;
        sw_sr[s]  <= '0;
      end
    end else begin
      lock_sr   <= {lock_sr[SYNC_STAGES-2:0], pll_locked};
      btn_sr[0] <= btn_raw;
      sw_sr[0]  <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        btn_sr[s] <= btn_sr[s-1];
        sw_sr[s]  <= sw_sr[s-1];
      end
    end
  end

  assign lock_sync = lock_sr[SYNC_STAGES-1];
  assign btn_sync  = btn_sr[SYNC_STAGES-1];
  assign sw_sync   = sw_sr[SYNC_STAGES-1];

  // Debounce: a button must differ from its debounced level for DB_CYCLES samples in a row.
  logic [DW-1:0]      db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] btn_db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
      btn_db    <= '0;
      btn_db_q  <= '0;
      btn_press <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_sync[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          btn_db[i] <= ~btn_db[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      btn_db_q  <= btn_db;
      btn_press <= btn_db & ~btn_db_q;
    end
  end

  logic          soft_rst;
  logic          mode_adv;
  logic [HW-1:0] hold_cnt;
  logic          hold_load;
  logic          rst_n_nxt;

  assign soft_rst = btn_press[RST_BTN];
  assign mode_adv = btn_press[MODE_BTN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (lock_sync) state_nxt = HOLD;
      HOLD: begin
        if (!lock_sync)          state_nxt = WAIT_LOCK;
        else if (hold_cnt == '0) state_nxt = RUN;
      end
      RUN: begin
        // lock loss wins over a soft reset arriving in the same cycle
        if (!lock_sync)    state_nxt = WAIT_LOCK;
        else if (soft_rst) state_nxt = HOLD;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    hold_load = (state_nxt == HOLD) && (state != HOLD);
    rst_n_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      proj_rst_n <= 1'b0;
    end else begin
      if (hold_load) begin
        hold_cnt <= HOLD_LOAD;
      end else if ((state == HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      proj_rst_n <= rst_n_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_mode <= 2'd0;
    end else if (mode_adv) begin
      led_mode <= led_mode + 2'd1;
    end
  end

  logic heartbeat;

`ifdef BOARD_CTRL_HEARTBEAT_EN
  logic [23:0] hb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt <= '0;
    end else begin
      hb_cnt <= hb_cnt + 24'd1;
    end
  end

  assign heartbeat = hb_cnt[23];
`else
  assign heartbeat = 1'b0;
`endif

  // Switch and button vectors resized to the LED width, missing bits read as 0.
  logic [NUM_LED-1:0] sw_ext;
  logic [NUM_LED-1:0] btn_ext;

  for (genvar i = 0; i < NUM_LED; i++) begin : g_ext
    if (i < NUM_SW) begin : g_sw
      assign sw_ext[i] = sw_sync[i];
    end else begin : g_sw_pad
      assign sw_ext[i] = 1'b0;
    end
    if (i < NUM_BTN) begin : g_btn
      assign btn_ext[i] = btn_db[i];
    end else begin : g_btn_pad
      assign btn_ext[i] = 1'b0;
    end
  end

  logic [NUM_LED-1:0] status;
  logic [NUM_LED-1:0] led_nxt;

  always_comb begin
    status              = '0;
    status[0]           = proj_rst_n;
    status[1]           = lock_sync;
    status[3:2]         = state;
    status[NUM_LED-1]   = heartbeat;
  end

  always_comb begin
    led_nxt = '0;
    case (led_mode)
      2'd0:    led_nxt = mon_in ^ sw_ext;
      2'd1:    led_nxt = mon_in;
      2'd2:    led_nxt = status;
      default: led_nxt = btn_ext;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule
